// File: rtl/add_seq_pkg.sv
// Shared constants and helpers for the byte-serial add/subtract sequencer.
package add_seq_pkg;

    localparam int unsigned BYTE_W = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Ceiling log2 for small positive values (0 for n <= 1).
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 31; i++) begin
            if ((32'd1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // Byte index width; never narrower than one bit so NBYTES=1 still has a register.
    function automatic int unsigned idx_width(input int unsigned n);
        return (clog2(n) > 0) ? clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ADD8bit.sv
// Existing 8-bit ripple-carry adder shared by the sequencer.
module ADD8bit (
    input  logic [7:0] a8bit,
    input  logic [7:0] b8bit,
    input  logic       inputCarry8bit,
    output logic [7:0] sum8bit,
    output logic       outputCarry8bit
);

    logic [8:0] carry;

    // Ripple the carry through eight full-adder cells.
    always_comb begin
        carry    = '0;
        sum8bit  = '0;
        carry[0] = inputCarry8bit;
        for (int i = 0; i < 8; i++) begin
            sum8bit[i]   = a8bit[i] ^ b8bit[i] ^ carry[i];
            carry[i + 1] = (a8bit[i] & b8bit[i]) | (carry[i] & (a8bit[i] ^ b8bit[i]));
        end
        outputCarry8bit = carry[8];
    end

endmodule

// File: rtl/add8_seq_ctrl.sv
// Byte-serial W-bit add/subtract sequencer driving one shared ADD8bit, LSB byte first.
module add8_seq_ctrl
    import add_seq_pkg::*;
#(
    parameter int unsigned NBYTES = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       sub,
    input  logic [BYTE_W*NBYTES-1:0]   opA,
    input  logic [BYTE_W*NBYTES-1:0]   opB,
    input  logic                       abort,
    output logic                       busy,
    output logic                       done,
    output logic [BYTE_W*NBYTES-1:0]   result,
    output logic                       carryOut,
    output logic                       overflow,
    output logic                       zero
);

    localparam int unsigned W     = BYTE_W * NBYTES;
    localparam int unsigned IDX_W = idx_width(NBYTES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES - 1);

    logic [1:0]       state_q;
    logic [1:0]       state_nxt;

    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic [W-1:0]     shadow_q;
    logic             carry_q;
    logic [IDX_W-1:0] idx_q;

    logic [W-1:0]     a_d;
    logic [W-1:0]     b_d;
    logic [W-1:0]     shadow_d;
    logic             carry_d;
    logic [IDX_W-1:0] idx_d;
    logic [W-1:0]     result_d;
    logic             carry_out_d;
    logic             overflow_d;
    logic             zero_d;
    logic             busy_d;
    logic             done_d;

    logic             accept_c;
    logic             last_c;
    logic [BYTE_W-1:0] a_byte_c;
    logic [BYTE_W-1:0] b_byte_c;
    logic [BYTE_W-1:0] sum_byte_c;
    logic             cout_byte_c;
    logic [W-1:0]     shadow_wr_c;

    assign accept_c = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && start;
    assign last_c   = (idx_q == IDX_LAST);

    // Select the current operand byte and merge the adder output into the shadow image.
    always_comb begin
        a_byte_c    = a_q[32'(idx_q) * BYTE_W +: BYTE_W];
        b_byte_c    = b_q[32'(idx_q) * BYTE_W +: BYTE_W];
        shadow_wr_c = shadow_q;
        shadow_wr_c[32'(idx_q) * BYTE_W +: BYTE_W] = sum_byte_c;
    end

    ADD8bit u_add8 (
        .a8bit           (a_byte_c),
        .b8bit           (b_byte_c),
        .inputCarry8bit  (carry_q),
        .sum8bit         (sum_byte_c),
        .outputCarry8bit (cout_byte_c)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state logic: abort beats completion; DONE re-accepts start without a bubble.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (abort)       state_nxt = ST_IDLE;
                else if (last_c) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                state_nxt = start ? ST_RUN : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Next values for datapath and outputs; visible results move only on completion.
    always_comb begin
        a_d         = a_q;
        b_d         = b_q;
        shadow_d    = shadow_q;
        carry_d     = carry_q;
        idx_d       = idx_q;
        result_d    = result;
        carry_out_d = carryOut;
        overflow_d  = overflow;
        zero_d      = zero;
        busy_d      = (state_nxt == ST_RUN);
        done_d      = (state_nxt == ST_DONE);

        if (accept_c) begin
            a_d      = opA;
            b_d      = sub ? ~opB : opB;
            carry_d  = sub;
            idx_d    = '0;
            shadow_d = '0;
        end else if ((state_q == ST_RUN) && !abort) begin
            shadow_d = shadow_wr_c;
            carry_d  = cout_byte_c;
            if (last_c) begin
                result_d    = shadow_wr_c;
                carry_out_d = cout_byte_c;
                overflow_d  = (a_q[W-1] == b_q[W-1]) && (sum_byte_c[BYTE_W-1] != a_q[W-1]);
                zero_d      = (shadow_wr_c == '0);
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            shadow_q <= '0;
            carry_q  <= 1'b0;
            idx_q    <= '0;
            result   <= '0;
            carryOut <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            shadow_q <= shadow_d;
            carry_q  <= carry_d;
            idx_q    <= idx_d;
            result   <= result_d;
            carryOut <= carry_out_d;
            overflow <= overflow_d;
            zero     <= zero_d;
            busy     <= busy_d;
            done     <= done_d;
        end
    end

endmodule
